// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, one stop bit.
// A one-entry holding buffer lets the next frame follow the stop bit with no idle gap.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  IN_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [DIV_WIDTH-1:0]  CLKS_PER_BIT,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg;
    logic [DIV_WIDTH-1:0]  div_reg;
    logic [DIV_WIDTH-1:0]  last_reg;
    logic [CNT_W-1:0]      bit_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic [DATA_WIDTH-1:0] buf_reg;
    logic                  buf_full_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  frame_done_reg;

    logic                  bit_tick;
    logic                  stop_end;
    logic                  accept;
    logic                  load_buf;
    logic                  load_direct;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_byte;
    logic [DIV_WIDTH-1:0]  last_next;

    always_comb begin
        bit_tick    = (div_reg == last_reg);
        stop_end    = (state_reg == STOP) && bit_tick;
        accept      = DATA_VALID && !buf_full_reg;
        load_buf    = stop_end && buf_full_reg;
        // A fresh byte skips the buffer when the line is free now or frees up at this edge.
        load_direct = accept && ((state_reg == IDLE) || (stop_end && !buf_full_reg));
        load_en     = load_buf || load_direct;
        load_byte   = load_buf ? buf_reg : P_DATA;
        last_next   = (CLKS_PER_BIT > DIV_WIDTH'(1)) ? (CLKS_PER_BIT - DIV_WIDTH'(1)) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            div_reg        <= '0;
            last_reg       <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            par_en_reg     <= 1'b0;
            par_bit_reg    <= 1'b0;
            buf_reg        <= '0;
            buf_full_reg   <= 1'b0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            if (load_buf) begin
                buf_full_reg <= 1'b0;
            end else if (accept && !load_direct) begin
                buf_reg      <= P_DATA;
                buf_full_reg <= 1'b1;
            end

            if (load_en) begin
                // Frame settings are latched here so mid-frame changes only affect later frames.
                shift_reg   <= load_byte;
                par_en_reg  <= PAR_EN;
                par_bit_reg <= (^load_byte) ^ PAR_TYP;
                last_reg    <= last_next;
                div_reg     <= '0;
                bit_reg     <= '0;
                state_reg   <= START;
                tx_reg      <= 1'b0;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        tx_reg   <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                    START: begin
                        if (bit_tick) begin
                            state_reg <= DATA;
                            div_reg   <= '0;
                            tx_reg    <= shift_reg[0];
                        end else begin
                            div_reg <= div_reg + DIV_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            div_reg <= '0;
                            if (bit_reg == CNT_W'(DATA_WIDTH - 1)) begin
                                if (par_en_reg) begin
                                    state_reg <= PARITY;
                                    tx_reg    <= par_bit_reg;
                                end else begin
                                    state_reg      <= STOP;
                                    tx_reg         <= 1'b1;
                                    frame_done_reg <= (last_reg == '0);
                                end
                            end else begin
                                bit_reg   <= bit_reg + CNT_W'(1);
                                shift_reg <= shift_reg >> 1;
                                tx_reg    <= shift_reg[1];
                            end
                        end else begin
                            div_reg <= div_reg + DIV_WIDTH'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_tick) begin
                            state_reg      <= STOP;
                            div_reg        <= '0;
                            tx_reg         <= 1'b1;
                            frame_done_reg <= (last_reg == '0);
                        end else begin
                            div_reg <= div_reg + DIV_WIDTH'(1);
                        end
                    end
                    STOP: begin
                        if (bit_tick) begin
                            state_reg <= IDLE;
                            div_reg   <= '0;
                            tx_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            div_reg        <= div_reg + DIV_WIDTH'(1);
                            frame_done_reg <= ((div_reg + DIV_WIDTH'(1)) == last_reg);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign TX_OUT     = tx_reg;
    assign BUSY       = busy_reg;
    assign FRAME_DONE = frame_done_reg;
    assign IN_READY   = !buf_full_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-of-line-levels reference model.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       IN_READY;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] CLKS_PER_BIT;
    logic       TX_OUT;
    logic       BUSY;
    logic       FRAME_DONE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .P_DATA       (P_DATA),
        .DATA_VALID   (DATA_VALID),
        .IN_READY     (IN_READY),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TX_OUT       (TX_OUT),
        .BUSY         (BUSY),
        .FRAME_DONE   (FRAME_DONE)
    );

    // Reference model: each entry is one future line cycle {frame_done, tx level}.
    logic [1:0] exp_q[$];
    logic [7:0] m_buf;
    bit         m_full = 1'b0;

    function automatic void expand(input logic [7:0] b);
        int   n;
        logic lv[$];
        n = (CLKS_PER_BIT > 8'd1) ? int'(CLKS_PER_BIT) : 1;
        lv.push_back(1'b0);
        for (int k = 0; k < 8; k++) lv.push_back(b[k]);
        if (PAR_EN) lv.push_back((^b) ^ PAR_TYP);
        lv.push_back(1'b1);
        for (int s = 0; s < lv.size(); s++)
            for (int j = 0; j < n; j++)
                exp_q.push_back({(s == lv.size() - 1) && (j == n - 1), lv[s]});
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            exp_q.delete();
            m_full = 1'b0;
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0 && m_full) begin
                expand(m_buf);
                m_full = 1'b0;
            end else if (DATA_VALID && !m_full) begin
                $display("accept byte 0x%02h par_en=%0b par_typ=%0b clks=%0d", P_DATA, PAR_EN, PAR_TYP, CLKS_PER_BIT);
                if (exp_q.size() == 0) expand(P_DATA);
                else begin
                    m_buf  = P_DATA;
                    m_full = 1'b1;
                end
            end
        end
    end

    // Expected {TX_OUT, BUSY, FRAME_DONE, IN_READY} for the current cycle.
    function automatic logic [3:0] model_vec();
        if (exp_q.size() == 0) return {1'b1, 1'b0, 1'b0, !m_full};
        return {exp_q[0][0], 1'b1, exp_q[0][1], !m_full};
    endfunction

    task automatic test_reset();
        RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; CLKS_PER_BIT = 8'd1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({TX_OUT, BUSY, IN_READY, FRAME_DONE} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_state: got tx/busy/rdy/done=%b, expected 1010", {TX_OUT, BUSY, IN_READY, FRAME_DONE});
        end
        RST = 1'b0;
    endtask

    // seq[k] is the required line level for slot k of the frame.
    task automatic test_single_frame(input logic [7:0] b, input logic pe, input logic pt,
                                     input logic [7:0] clks, input logic [10:0] seq, input string name);
        int n, total, busy_cnt, fd_cnt;
        n = (clks > 8'd1) ? int'(clks) : 1;
        total = (pe ? 11 : 10) * n;
        busy_cnt = 0; fd_cnt = 0;
        @(negedge CLK);
        PAR_EN = pe; PAR_TYP = pt; CLKS_PER_BIT = clks; P_DATA = b; DATA_VALID = 1'b1;
        for (int i = 0; i < total + 4; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL %s_model cycle %0d: got %b, expected %b", name, i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (BUSY) busy_cnt++;
            if (FRAME_DONE) fd_cnt++;
            if (i < total && (i % n) == n / 2) begin
                checks++;
                if (TX_OUT !== seq[i / n]) begin
                    errors++;
                    $display("FAIL %s_slot%0d: got %b, expected %b", name, i / n, TX_OUT, seq[i / n]);
                end
            end
        end
        checks++;
        if (busy_cnt != total || fd_cnt != 1) begin
            errors++;
            $display("FAIL %s_length: got busy=%0d done=%0d, expected busy=%0d done=1", name, busy_cnt, fd_cnt, total);
        end
        checks++;
        if ({TX_OUT, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL %s_idle_after: got tx/busy=%b, expected 10", name, {TX_OUT, BUSY});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int         acc [3];
        int         idx, busy_cnt, fd_cnt;
        logic       prev_ready;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        acc[0] = -9; acc[1] = -9; acc[2] = -9;
        idx = 0; busy_cnt = 0; fd_cnt = 0;
        @(negedge CLK);
        CLKS_PER_BIT = 8'd4; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        P_DATA = bytes[0]; DATA_VALID = 1'b1;
        prev_ready = IN_READY;
        for (int i = 0; i < 140; i++) begin
            @(negedge CLK);
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL b2b_model cycle %0d: got %b, expected %b", i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (prev_ready && DATA_VALID && idx < 3) begin
                acc[idx] = i - 1;
                idx++;
                if (idx < 3) P_DATA = bytes[idx];
                else DATA_VALID = 1'b0;
            end
            prev_ready = IN_READY;
            if (i < 132 && BUSY) busy_cnt++;
            if (FRAME_DONE) fd_cnt++;
            if (i == 1 || i == 60) begin
                checks++;
                if (IN_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_full cycle %0d: got %b, expected 0", i, IN_READY);
                end
            end
            if (i == 132) begin
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy_end: got %b, expected 0", BUSY);
                end
            end
        end
        checks++;
        if (acc[1] != 0 || acc[2] != 44) begin
            errors++;
            $display("FAIL b2b_accept_cycles: got %0d,%0d, expected 0,44", acc[1], acc[2]);
        end
        checks++;
        if (busy_cnt != 132 || fd_cnt != 3) begin
            errors++;
            $display("FAIL b2b_gapless: got busy=%0d done=%0d, expected busy=132 done=3", busy_cnt, fd_cnt);
        end
    endtask

    task automatic test_config_change();
        int   fd_at [4];
        int   fd_n, busy_cnt;
        logic pt;
        pt = 1'($urandom_range(0, 1));
        fd_n = 0; busy_cnt = 0;
        @(negedge CLK);
        CLKS_PER_BIT = 8'd8; PAR_EN = 1'b1; PAR_TYP = pt;
        P_DATA = 8'h5A; DATA_VALID = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(negedge CLK);
            if (i == 0) P_DATA = 8'hA5;
            if (i == 1) DATA_VALID = 1'b0;
            if (i == 30) begin
                PAR_EN = 1'b0;
                CLKS_PER_BIT = 8'd16;
            end
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL cfg_model cycle %0d: got %b, expected %b", i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (BUSY) busy_cnt++;
            if (FRAME_DONE && fd_n < 4) begin
                fd_at[fd_n] = i;
                fd_n++;
            end
            if (i == 76) begin
                checks++;
                if (TX_OUT !== (1'b0 ^ pt)) begin
                    errors++;
                    $display("FAIL cfg_parity_kept: got %b, expected %b", TX_OUT, pt);
                end
            end
        end
        checks++;
        if (fd_n != 2 || fd_at[0] != 87 || fd_at[1] != 247 || busy_cnt != 248) begin
            errors++;
            $display("FAIL cfg_frame_timing: got pulses=%0d at %0d,%0d busy=%0d, expected 2 at 87,247 busy=248",
                     fd_n, fd_at[0], fd_at[1], busy_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int busy_cnt, fd_cnt;
        busy_cnt = 0; fd_cnt = 0;
        @(negedge CLK);
        CLKS_PER_BIT = 8'd4; PAR_EN = 1'b1; PAR_TYP = 1'($urandom_range(0, 1));
        P_DATA = 8'($urandom); DATA_VALID = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge CLK);
            if (i == 0) P_DATA = 8'($urandom);
            if (i == 1) DATA_VALID = 1'b0;
            if (i == 18) begin
                checks++;
                if ({TX_OUT, BUSY, IN_READY, FRAME_DONE} !== 4'b1010) begin
                    errors++;
                    $display("FAIL rst_mid_state: got tx/busy/rdy/done=%b, expected 1010", {TX_OUT, BUSY, IN_READY, FRAME_DONE});
                end
                RST = 1'b0;
            end
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL rst_mid_model cycle %0d: got %b, expected %b", i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (i >= 18 && BUSY) busy_cnt++;
            if (i == 17) RST = 1'b1;
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_buffer_dropped: got busy cycles=%0d, expected 0", busy_cnt);
        end
        @(negedge CLK);
        P_DATA = 8'($urandom); DATA_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL rst_mid_after cycle %0d: got %b, expected %b", i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (FRAME_DONE) fd_cnt++;
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL rst_mid_new_frame: got done pulses=%0d, expected 1", fd_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1600; i++) begin
            @(negedge CLK);
            checks++;
            if ({TX_OUT, BUSY, FRAME_DONE, IN_READY} !== model_vec()) begin
                errors++;
                $display("FAIL rand_model cycle %0d: got %b, expected %b", i, {TX_OUT, BUSY, FRAME_DONE, IN_READY}, model_vec());
            end
            if (i < 1500) begin
                DATA_VALID   = ($urandom_range(0, 3) != 0);
                P_DATA       = 8'($urandom);
                PAR_EN       = 1'($urandom_range(0, 1));
                PAR_TYP      = 1'($urandom_range(0, 1));
                CLKS_PER_BIT = 8'($urandom_range(0, 3));
            end else begin
                DATA_VALID = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hAA, 1'b1, 1'b1, 8'd8, 11'b11101010100, "frame_aa");
        test_single_frame(8'hBB, 1'b1, 1'b0, 8'd1, 11'b10101110110, "frame_bb");
        test_single_frame(8'hCC, 1'b0, 1'b0, 8'd0, 11'b01110011000, "frame_cc");
        test_back_to_back();
        test_config_change();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
